// File: rtl/pipe_buffer.sv
// First-in first-out pipeline buffer between two decode stages, with registered
// ready/valid, synchronous flush and asynchronous reset.
module pipe_buffer #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              input_valid_i,
    output logic              input_ready_o,
    input  logic [DATA_W-1:0] input_data_i,
    input  logic              output_ready_i,
    output logic              output_valid_o,
    output logic [DATA_W-1:0] output_data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign input_ready_o  = (count_q < CNT_W'(DEPTH));
    assign output_valid_o = (count_q != '0);
    assign count_o        = count_q;
    assign output_data_o  = output_valid_o ? mem_q[rdPtr_q] : '0;

    assign push = input_valid_i & input_ready_o & ~flush_i;
    assign pop  = output_valid_o & output_ready_i & ~flush_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = nextPtr(wrPtr_q);
            if (pop)  rdPtr_d = nextPtr(rdPtr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is never visible while empty, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wrPtr_q] <= input_data_i;
    end

endmodule

// File: tb/tb_pipe_buffer.sv
// Bench for pipe_buffer: a DEPTH=2 and a DEPTH=3 instance share stimulus and are
// each checked against a queue model of FIFO behaviour.
module tb_pipe_buffer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       input_valid_i;
    logic [7:0] input_data_i;
    logic       output_ready_i;

    logic       inRdy2, outVld2, inRdy3, outVld3;
    logic [7:0] outData2, outData3;
    logic [1:0] count2, count3;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model2[$];
    logic [7:0] model3[$];

    always #5 clk_i = ~clk_i;

    pipe_buffer #(.DATA_W(8), .DEPTH(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .input_valid_i(input_valid_i), .input_ready_o(inRdy2),
        .input_data_i(input_data_i), .output_ready_i(output_ready_i),
        .output_valid_o(outVld2), .output_data_o(outData2), .count_o(count2)
    );

    pipe_buffer #(.DATA_W(8), .DEPTH(3)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .input_valid_i(input_valid_i), .input_ready_o(inRdy3),
        .input_data_i(input_data_i), .output_ready_i(output_ready_i),
        .output_valid_o(outVld3), .output_data_o(outData3), .count_o(count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs of both instances compared with what the queues say they should be.
    task automatic checkOutput(input string tag);
        chk({tag, "/d2.count"}, 32'(count2), 32'(model2.size()));
        chk({tag, "/d2.valid"}, 32'(outVld2), 32'(model2.size() != 0));
        chk({tag, "/d2.ready"}, 32'(inRdy2), 32'(model2.size() < 2));
        chk({tag, "/d2.data"}, 32'(outData2), (model2.size() != 0) ? 32'(model2[0]) : 32'h0);
        chk({tag, "/d3.count"}, 32'(count3), 32'(model3.size()));
        chk({tag, "/d3.valid"}, 32'(outVld3), 32'(model3.size() != 0));
        chk({tag, "/d3.ready"}, 32'(inRdy3), 32'(model3.size() < 3));
        chk({tag, "/d3.data"}, 32'(outData3), (model3.size() != 0) ? 32'(model3[0]) : 32'h0);
        chk({tag, "/d3.bound"}, 32'(count3 <= 2'd3 && model3.size() <= 3), 32'd1);
    endtask

    task automatic modelEdge(inout logic [7:0] q[$], input int depth,
                             input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
        bit doPush, doPop;
        doPush = iv && (q.size() < depth) && !fl;
        doPop  = (q.size() != 0) && ordy && !fl;
        if (fl) q.delete();
        else begin
            if (doPop) void'(q.pop_front());
            if (doPush) q.push_back(d);
        end
    endtask

    // One clock: drive inputs away from the edge, advance models at the edge, check after it.
    task automatic applyStimulus(input string tag, input logic fl, input logic iv,
                                 input logic [7:0] d, input logic ordy);
        flush_i        = fl;
        input_valid_i  = iv;
        input_data_i   = d;
        output_ready_i = ordy;
        @(posedge clk_i);
        modelEdge(model2, 2, fl, iv, d, ordy);
        modelEdge(model3, 3, fl, iv, d, ordy);
        #1;
        checkOutput(tag);
    endtask

    task automatic asyncReset(input string tag);
        #2 rst_i = 1'b1;
        model2.delete();
        model3.delete();
        #1 checkOutput(tag);
        #2 rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        input_valid_i = 1'b0;
        input_data_i = 8'h00;
        output_ready_i = 1'b1;
        #1 checkOutput("reset");
        repeat (2) @(posedge clk_i);
        #1 checkOutput("resetHeld");
        rst_i = 1'b0;

        applyStimulus("pushA1", 1'b0, 1'b1, 8'hA1, 1'b0);
        applyStimulus("pushB2", 1'b0, 1'b1, 8'hB2, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("fullHoldC3", 1'b0, 1'b1, 8'hC3, 1'b0);
        applyStimulus("popA1", 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("drain", 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("drain2", 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("emptyPop", 1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 10; i++) applyStimulus("stream", 1'b0, 1'b1, 8'(i), 1'b1);
        applyStimulus("streamEnd", 1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus("wrapPush", 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
            if (i % 2 == 1) applyStimulus("wrapPop", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 4; i++) applyStimulus("wrapDrain", 1'b0, 1'b0, 8'h00, 1'b1);

        applyStimulus("fill1", 1'b0, 1'b1, 8'h11, 1'b0);
        applyStimulus("fill2", 1'b0, 1'b1, 8'h22, 1'b0);
        applyStimulus("flush", 1'b1, 1'b1, 8'hEE, 1'b1);
        applyStimulus("postFlush", 1'b0, 1'b1, 8'h33, 1'b1);
        applyStimulus("postFlush2", 1'b0, 1'b0, 8'h00, 1'b1);

        applyStimulus("preRst1", 1'b0, 1'b1, 8'h55, 1'b0);
        applyStimulus("preRst2", 1'b0, 1'b1, 8'h66, 1'b0);
        asyncReset("asyncRst");
        applyStimulus("firstPush", 1'b0, 1'b1, 8'h77, 1'b0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 19) == 0), 1'($urandom),
                          8'($urandom), 1'($urandom));
            if (i == 150) asyncReset("randomRst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
